// File: rtl/jtag_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | jtag_pkg : JTAG master state encoding and TMS sequences (LSB first)|
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package jtag_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_TRST  = 3'd1,
      ST_HEAD  = 3'd2,
      ST_SHIFT = 3'd3,
      ST_TAIL  = 3'd4
   } state_e;

   localparam int SEQ_W = 6;

   localparam logic [2:0] DR_HEAD      = 3'b001;
   localparam logic [2:0] DR_HEAD_LEN  = 3'd3;
   localparam logic [3:0] IR_HEAD      = 4'b0011;
   localparam logic [2:0] IR_HEAD_LEN  = 3'd4;
   localparam logic [1:0] TAIL         = 2'b01;
   localparam logic [2:0] TAIL_LEN     = 3'd2;
   localparam logic [5:0] TRST_SEQ     = 6'b011111;
   localparam logic [2:0] TRST_LEN     = 3'd6;

   localparam int DEFAULT_CLK_DIV = 4;

   function automatic logic [SEQ_W-1:0] head_seq(input logic is_ir);
      return is_ir ? SEQ_W'(IR_HEAD) : SEQ_W'(DR_HEAD);
   endfunction

   function automatic logic [2:0] head_len(input logic is_ir);
      return is_ir ? IR_HEAD_LEN : DR_HEAD_LEN;
   endfunction

endpackage
`default_nettype wire

// File: rtl/jtag_master_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | jtag_master_if : host command interface of the JTAG master        |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
interface jtag_master_if #(
   parameter int MAX_LEN = 32
);
   localparam int LW = $clog2(MAX_LEN + 1);

   logic               start;
   logic               reset_tap;
   logic               is_ir;
   logic [LW-1:0]      len;
   logic [MAX_LEN-1:0] din;
   logic [MAX_LEN-1:0] dout;
   logic               busy;
   logic               done;

   modport master (
      output start, reset_tap, is_ir, len, din,
      input  dout, busy, done
   );

   modport slave (
      input  start, reset_tap, is_ir, len, din,
      output dout, busy, done
   );

endinterface
`default_nettype wire

// File: rtl/jtag_tck_gen.sv
`default_nettype none
// +------------------------------------------------------------------+
// | jtag_tck_gen : TCK divider with one-cycle rise/fall strobes       |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module jtag_tck_gen #(
   parameter int CLK_DIV = 4
) (
   input  wire  clk,
   input  wire  rst_n,
   input  wire  en,
   output logic tck,
   output logic rise,
   output logic fall
);

   localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [CW-1:0] C_TERM = CW'(CLK_DIV - 1);

   logic [CW-1:0] r_cnt;
   logic          w_term;

   // Strobes mark the clk edge on which TCK toggles, so TDO capture lines up with the rise.
   assign w_term = (r_cnt == C_TERM);
   assign rise   = en & ~tck & w_term;
   assign fall   = en &  tck & w_term;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
         tck   <= 1'b0;
      end else if (!en) begin
         r_cnt <= '0;
         tck   <= 1'b0;
      end else if (w_term) begin
         r_cnt <= '0;
         tck   <= ~tck;
      end else begin
         r_cnt <= r_cnt + CW'(1);
      end
   end

endmodule
`default_nettype wire

// File: rtl/jtag_master.sv
`default_nettype none
// +------------------------------------------------------------------+
// | jtag_master : JTAG scan initiator (IR/DR scans, TAP reset)        |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module jtag_master import jtag_pkg::*; #(
   parameter int MAX_LEN = 32,
   parameter int CLK_DIV = DEFAULT_CLK_DIV
) (
   input  wire          clk,
   input  wire          rst_n,
   jtag_master_if.slave host,
   output logic         tck,
   output logic         tms,
   output logic         tdi,
   input  wire          tdo
);

   localparam int LW = $clog2(MAX_LEN + 1);
   localparam logic [LW-1:0] C_MAX_LEN = LW'(MAX_LEN);

   state_e             r_state;
   logic               r_is_ir;
   logic [LW-1:0]      r_len;
   logic [LW-1:0]      r_bit_cnt;
   logic [2:0]         r_seq_cnt;
   logic [SEQ_W-1:0]   r_tms_seq;
   logic [MAX_LEN-1:0] r_din;
   logic [MAX_LEN-1:0] r_dout;
   logic [MAX_LEN-1:0] r_mask;
   logic               r_busy;
   logic               r_done;

   logic               w_en;
   logic               w_rise;
   logic               w_fall;
   logic [LW-1:0]      w_len_c;
   logic [SEQ_W-1:0]   w_head;
   logic               w_head_last;
   logic               w_bit_last;

   assign w_en        = (r_state != ST_IDLE);
   assign w_len_c     = (host.len > C_MAX_LEN) ? C_MAX_LEN : host.len;
   assign w_head      = head_seq(host.is_ir);
   assign w_head_last = (r_seq_cnt == head_len(r_is_ir) - 3'd1);
   assign w_bit_last  = (r_bit_cnt == r_len - LW'(1));

   assign host.dout = r_dout;
   assign host.busy = r_busy;
   assign host.done = r_done;

   jtag_tck_gen #(.CLK_DIV(CLK_DIV)) u_tck_gen (
      .clk  (clk),
      .rst_n(rst_n),
      .en   (w_en),
      .tck  (tck),
      .rise (w_rise),
      .fall (w_fall)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= ST_IDLE;
         r_is_ir   <= 1'b0;
         r_len     <= '0;
         r_bit_cnt <= '0;
         r_seq_cnt <= '0;
         r_tms_seq <= '0;
         r_din     <= '0;
         r_dout    <= '0;
         r_mask    <= '0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         tms       <= 1'b1;
         tdi       <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (r_busy) begin
                  // Zero-length scan: complete one cycle after acceptance.
                  r_busy <= 1'b0;
                  r_done <= 1'b1;
               end else if (host.reset_tap) begin
                  r_state   <= ST_TRST;
                  r_seq_cnt <= '0;
                  tms       <= TRST_SEQ[0];
                  r_tms_seq <= TRST_SEQ >> 1;
                  tdi       <= 1'b0;
                  r_busy    <= 1'b1;
               end else if (host.start) begin
                  r_is_ir   <= host.is_ir;
                  r_len     <= w_len_c;
                  r_din     <= host.din;
                  r_dout    <= '0;
                  r_mask    <= MAX_LEN'(1);
                  r_busy    <= 1'b1;
                  tdi       <= 1'b0;
                  if (w_len_c != '0) begin
                     r_state   <= ST_HEAD;
                     r_seq_cnt <= '0;
                     tms       <= w_head[0];
                     r_tms_seq <= w_head >> 1;
                  end
               end
            end

            ST_TRST: begin
               if (w_fall) begin
                  if (r_seq_cnt == TRST_LEN - 3'd1) begin
                     r_state <= ST_IDLE;
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                  end else begin
                     r_seq_cnt <= r_seq_cnt + 3'd1;
                     tms       <= r_tms_seq[0];
                     r_tms_seq <= r_tms_seq >> 1;
                  end
               end
            end

            ST_HEAD: begin
               if (w_fall) begin
                  if (w_head_last) begin
                     r_state   <= ST_SHIFT;
                     r_bit_cnt <= '0;
                     tdi       <= r_din[0];
                     r_din     <= r_din >> 1;
                     tms       <= (r_len == LW'(1));
                  end else begin
                     r_seq_cnt <= r_seq_cnt + 3'd1;
                     tms       <= r_tms_seq[0];
                     r_tms_seq <= r_tms_seq >> 1;
                  end
               end
            end

            ST_SHIFT: begin
               if (w_rise) begin
                  if (tdo) begin
                     r_dout <= r_dout | r_mask;
                  end
                  r_mask <= r_mask << 1;
               end
               if (w_fall) begin
                  if (w_bit_last) begin
                     r_state   <= ST_TAIL;
                     r_seq_cnt <= '0;
                     tms       <= TAIL[0];
                     r_tms_seq <= SEQ_W'(TAIL >> 1);
                     tdi       <= 1'b0;
                  end else begin
                     r_bit_cnt <= r_bit_cnt + LW'(1);
                     tdi       <= r_din[0];
                     r_din     <= r_din >> 1;
                     tms       <= (r_bit_cnt + LW'(1) == r_len - LW'(1));
                  end
               end
            end

            ST_TAIL: begin
               if (w_fall) begin
                  if (r_seq_cnt == TAIL_LEN - 3'd1) begin
                     r_state <= ST_IDLE;
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                  end else begin
                     r_seq_cnt <= r_seq_cnt + 3'd1;
                     tms       <= r_tms_seq[0];
                     r_tms_seq <= r_tms_seq >> 1;
                  end
               end
            end

            default: begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire
